// File: rtl/ita_hwpe_package.sv
// Shared types and constants for the ITA HWPE stream path.
// Holds the multi-lane fence state encoding and counter width.
package ita_hwpe_package;

  localparam int unsigned FENCE_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    FENCE_IDLE = 2'd0,
    FENCE_RUN  = 2'd1,
    FENCE_DONE = 2'd2
  } fence_state_e;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle with byte strobes.
// The source drives valid/data/strb, the sink drives ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                      valid;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     data;
  logic [DATA_WIDTH/8-1:0]   strb;

  modport source (
    output valid, data, strb,
    input  ready
  );

  modport sink (
    input  valid, data, strb,
    output ready
  );

endinterface

// File: rtl/hwpe_stream_fifo.sv
// Registered-output circular FIFO used as a per-lane skid buffer.
// A pop and a push in the same cycle are applied pop-then-push.
module hwpe_stream_fifo #(
  parameter int unsigned DATA_WIDTH = 36,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  test_mode_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]         rd_q, rd_d;
  logic [AW-1:0]         wr_q, wr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  do_push, do_pop;
  logic                  unused_test_mode;

  assign unused_test_mode = test_mode_i;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(FIFO_DEPTH));
  assign data_o  = mem_q[rd_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = data_i;
        wr_d        = ptr_inc(wr_q);
      end
      if (do_pop) begin
        rd_d = ptr_inc(rd_q);
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ita_hwpe_stream_fence_multi.sv
// N-lane stream fence: releases one aligned beat per lane per group,
// with per-lane skid FIFOs, lane disable and a bounded job length.
module ita_hwpe_stream_fence_multi
  import ita_hwpe_package::*;
#(
  parameter int unsigned NB_STREAMS = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_WIDTH  = FENCE_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  test_mode_i,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  len_i,
  input  logic [NB_STREAMS-1:0] lane_disable_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  beat_cnt_o,
  hwpe_stream_intf_stream.sink   push_i [NB_STREAMS],
  hwpe_stream_intf_stream.source pop_o  [NB_STREAMS]
);

  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned FW = DATA_WIDTH + SW;

  fence_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [NB_STREAMS-1:0] dis_q, dis_d;
  logic [NB_STREAMS-1:0] taken_q, taken_d;
  logic                  zdone_q, zdone_d;

  logic [NB_STREAMS-1:0] empty, full, avail;
  logic [NB_STREAMS-1:0] push_rdy, fifo_push, fifo_pop;
  logic [NB_STREAMS-1:0] pop_vld, pop_hs;
  logic                  run, group_ok, complete, last;
  logic                  rst_n;

  assign rst_n    = ~rst_i;
  assign run      = (state_q == FENCE_RUN);
  assign avail    = dis_q | ~empty;
  assign group_ok = run & (&avail);
  assign complete = group_ok & (&(taken_q | pop_hs));
  assign last     = (cnt_q == len_q - CNT_WIDTH'(1));
  assign fifo_pop = {NB_STREAMS{complete}} & ~dis_q;

  assign busy_o     = run;
  assign done_o     = (state_q == FENCE_DONE) | zdone_q;
  assign beat_cnt_o = cnt_q;

  for (genvar k = 0; k < int'(NB_STREAMS); k++) begin : g_lane
    logic [FW-1:0] head;

    assign push_rdy[k]     = run & ~dis_q[k] & ~full[k];
    assign push_i[k].ready = push_rdy[k];
    assign fifo_push[k]    = push_i[k].valid & push_rdy[k];

    hwpe_stream_fifo #(
      .DATA_WIDTH (FW),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) i_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_n),
      .clear_i     (clear_i),
      .test_mode_i (test_mode_i),
      .push_i      (fifo_push[k]),
      .data_i      ({push_i[k].strb, push_i[k].data}),
      .pop_i       (fifo_pop[k]),
      .data_o      (head),
      .empty_o     (empty[k]),
      .full_o      (full[k])
    );

    // Disabled lanes present zero beats so the engine sees a fixed shape.
    assign pop_vld[k]     = group_ok & ~taken_q[k];
    assign pop_o[k].valid = pop_vld[k];
    assign pop_o[k].data  = dis_q[k] ? '0 : head[DATA_WIDTH-1:0];
    assign pop_o[k].strb  = dis_q[k] ? '0 : head[FW-1:DATA_WIDTH];
    assign pop_hs[k]      = pop_vld[k] & pop_o[k].ready;
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    dis_d   = dis_q;
    taken_d = taken_q;
    zdone_d = 1'b0;
    if (clear_i) begin
      state_d = FENCE_IDLE;
      cnt_d   = '0;
      taken_d = '0;
    end else begin
      unique case (state_q)
        FENCE_IDLE: begin
          if (start_i) begin
            cnt_d = '0;
            if (len_i == '0) begin
              zdone_d = 1'b1;
            end else begin
              len_d   = len_i;
              dis_d   = lane_disable_i;
              taken_d = '0;
              state_d = FENCE_RUN;
            end
          end
        end
        FENCE_RUN: begin
          taken_d = complete ? '0 : (taken_q | pop_hs);
          if (complete) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (last) begin
              state_d = FENCE_DONE;
            end
          end
        end
        FENCE_DONE: state_d = FENCE_IDLE;
        default:    state_d = FENCE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FENCE_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      dis_q   <= '0;
      taken_q <= '0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      dis_q   <= dis_d;
      taken_q <= taken_d;
      zdone_q <= zdone_d;
    end
  end

endmodule
